instr_stream_loader: RTL
========================

Name: instr_stream_loader

Overview:
- Host-side instruction store that sits directly upstream of tpu_top's fetch port and drives its instruction input from the fetch address.
- Receives a framed program as a byte stream from the UART RX byte decoder and assembles big-endian 32-bit instruction words into an on-chip program memory.
- Validates each frame with a length check and an XOR checksum, then pulses a start strobe.
- Serves NOPs (32'h0) whenever no valid program is loaded.

Parameters:
DEPTH, 32, number of instruction words in program memory (power of two, ≤256)
ADDR_W, 8, width of fetch address / word count
TIMEOUT_CYCLES, 100000, max idle clocks between bytes inside a frame before abort

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous assert, active-low
rx_valid  input  1  one-cycle strobe: rx_data holds a received byte
rx_data  input  8  received byte
fetch_addr  input  ADDR_W  instruction address from TPU fetch stage
fetch_data  output  32  instruction word to TPU fetch stage (combinational from fetch_addr)
load_busy  output  1  frame reception in progress
load_done  output  1  one-cycle pulse: frame accepted
tpu_start  output  1  one-cycle pulse, coincident with load_done
load_error  output  1  sticky: last frame rejected; cleared by next valid header
err_code  output  2  0 none, 1 bad length, 2 checksum mismatch, 3 timeout
prog_valid  output  1  memory holds a verified program
prog_len  output  ADDR_W  word count of the verified program

Behaviour:
- Reset (asynchronous, active-low): state IDLE; every output 0; prog_len 0; byte/word counters and checksum cleared. Memory contents are not reset; prog_valid=0 masks them.
- Frame format: header 0xA5, count byte N, N×4 data bytes (MSB first per word), checksum byte. Checksum = XOR of N and all data bytes; the header is excluded.
- State machine:
  - IDLE: rx_valid with 0xA5 → COUNT; load_busy=1, load_error=0, err_code=0, prog_valid=0. Any other byte is ignored.
  - COUNT: N==0 or N>DEPTH → IDLE with load_error=1, err_code=1. Otherwise latch N, seed checksum=N, go to DATA.
  - DATA: shift each byte into a 32-bit assembler and XOR it into the checksum. On the 4th byte of a word, write the word to mem[word_idx] in that same clock edge and increment word_idx. After word N-1 completes → CHECK. 0xA5 inside data is plain data; there is no resync.
  - CHECK: byte == checksum → IDLE. On the following cycle: load_done=1 and tpu_start=1 for exactly one cycle; prog_valid=1; prog_len=N; load_busy=0. Mismatch → IDLE with load_error=1, err_code=2, prog_valid stays 0.
- Timeout:
  - Counter clears on every accepted byte and counts while state≠IDLE.
  - Reaching TIMEOUT_CYCLES → IDLE, load_error=1, err_code=3, load_busy=0.
- load_busy is 1 in COUNT/DATA/CHECK only.
- Fetch:
  - fetch_data = mem[fetch_addr] when prog_valid && fetch_addr < prog_len; otherwise 32'h0.
  - Purely combinational: zero-cycle latency, matching the TPU's same-cycle fetch expectation.
  - While a new frame loads, prog_valid=0, so the TPU sees NOPs and never sees a partially written program.
- rx_valid is never back-to-back-guaranteed; a byte may arrive every cycle and must be accepted.
- Reset mid-frame: frame discarded, prog_valid=0, no load_done.

Test Plan:
- Valid frame A5 02 08 00 00 00 04 00 00 0C 02 → mem[0]=0x08000000, mem[1]=0x0400000C; one-cycle load_done/tpu_start one clock after checksum byte; prog_valid=1; prog_len=2. fetch_addr=1 → 0x0400000C; fetch_addr=2 → 0x00000000.
- Same frame with checksum 0x03 → load_error=1, err_code=2, prog_valid=0, no tpu_start; fetch_addr=0 → 0x0.
- A5 00 and A5 21 (DEPTH=32) → each aborts after the count byte with err_code=1; a following valid frame clears load_error and loads.
- A5 01 08 then silence for TIMEOUT_CYCLES (bench uses TIMEOUT_CYCLES=50) → err_code=3 at cycle 50 after last byte, load_busy falls; the next 0xA5 restarts cleanly.
- Leading junk 00 FF 13 then valid frame, bytes presented on consecutive cycles; frame contains data byte 0xA5 → junk ignored, 0xA5 stored as data, load succeeds.
- rst_n low mid-DATA → all outputs 0 asynchronously; after release a full valid frame loads correctly.

Source files
------------

// File: rtl/instr_stream_loader.sv
// instr_stream_loader: receives a framed program over a byte stream, assembles
// big-endian 32-bit words into program memory, verifies length and XOR checksum,
// and serves the verified program (or NOPs) to the TPU fetch stage.
module instr_stream_loader #(
    parameter int DEPTH          = 32,
    parameter int ADDR_W         = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [31:0]       fetch_data,
    output logic              load_busy,
    output logic              load_done,
    output logic              tpu_start,
    output logic              load_error,
    output logic [1:0]        err_code,
    output logic              prog_valid,
    output logic [ADDR_W-1:0] prog_len
);

    localparam int          IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [8:0]  DEPTH_9 = 9'(DEPTH);
    localparam logic [7:0]  HEADER  = 8'hA5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COUNT,
        S_DATA,
        S_CHECK
    } state_t;

    state_t               r_state;
    state_t               w_stateNext;

    logic [31:0]          r_mem [DEPTH];
    logic [7:0]           r_count;
    logic [7:0]           r_csum;
    logic [23:0]          r_asm;
    logic [1:0]           r_byteIdx;
    logic [7:0]           r_wordIdx;
    logic [TIMER_W-1:0]   r_timer;
    logic                 r_loadDone;
    logic                 r_loadError;
    logic [1:0]           r_errCode;
    logic                 r_progValid;
    logic [ADDR_W-1:0]    r_progLen;

    logic                 w_hdrAccept;
    logic                 w_countOk;
    logic                 w_dataByte;
    logic                 w_wordWrite;
    logic                 w_good;
    logic                 w_fail;
    logic [1:0]           w_failCode;
    logic                 w_timeout;
    logic [31:0]          w_word;

    // A byte arriving on the same cycle the idle limit would be hit still counts as activity.
    assign w_timeout = (r_state != S_IDLE) && !rx_valid &&
                       (r_timer == TIMER_W'(TIMEOUT_CYCLES - 1));
    assign w_word    = {r_asm, rx_data};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state decode plus single-cycle event strobes for the datapath.
    always_comb begin
        w_stateNext = r_state;
        w_hdrAccept = 1'b0;
        w_countOk   = 1'b0;
        w_dataByte  = 1'b0;
        w_wordWrite = 1'b0;
        w_good      = 1'b0;
        w_fail      = 1'b0;
        w_failCode  = 2'd0;
        case (r_state)
            S_IDLE: begin
                if (rx_valid && rx_data == HEADER) begin
                    w_hdrAccept = 1'b1;
                    w_stateNext = S_COUNT;
                end
            end
            S_COUNT: begin
                if (rx_valid) begin
                    if (rx_data == 8'd0 || {1'b0, rx_data} > DEPTH_9) begin
                        w_fail      = 1'b1;
                        w_failCode  = 2'd1;
                        w_stateNext = S_IDLE;
                    end else begin
                        w_countOk   = 1'b1;
                        w_stateNext = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (rx_valid) begin
                    w_dataByte = 1'b1;
                    if (r_byteIdx == 2'd3) begin
                        w_wordWrite = 1'b1;
                        if (r_wordIdx == r_count - 8'd1) begin
                            w_stateNext = S_CHECK;
                        end
                    end
                end
            end
            S_CHECK: begin
                if (rx_valid) begin
                    w_stateNext = S_IDLE;
                    if (rx_data == r_csum) begin
                        w_good = 1'b1;
                    end else begin
                        w_fail     = 1'b1;
                        w_failCode = 2'd2;
                    end
                end
            end
            default: begin
                w_stateNext = S_IDLE;
            end
        endcase
        if (w_timeout) begin
            w_fail      = 1'b1;
            w_failCode  = 2'd3;
            w_stateNext = S_IDLE;
        end
    end

    // Frame datapath: counters, checksum, word assembler, status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count     <= 8'd0;
            r_csum      <= 8'd0;
            r_asm       <= 24'd0;
            r_byteIdx   <= 2'd0;
            r_wordIdx   <= 8'd0;
            r_timer     <= '0;
            r_loadDone  <= 1'b0;
            r_loadError <= 1'b0;
            r_errCode   <= 2'd0;
            r_progValid <= 1'b0;
            r_progLen   <= '0;
        end else begin
            r_loadDone <= w_good;
            if (r_state == S_IDLE || rx_valid) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + TIMER_W'(1);
            end
            if (w_hdrAccept) begin
                r_loadError <= 1'b0;
                r_errCode   <= 2'd0;
                r_progValid <= 1'b0;
                r_byteIdx   <= 2'd0;
                r_wordIdx   <= 8'd0;
                r_csum      <= 8'd0;
            end
            if (w_countOk) begin
                r_count <= rx_data;
                r_csum  <= rx_data;
            end
            if (w_dataByte) begin
                r_csum    <= r_csum ^ rx_data;
                r_asm     <= w_word[23:0];
                r_byteIdx <= r_byteIdx + 2'd1;
            end
            if (w_wordWrite) begin
                r_wordIdx <= r_wordIdx + 8'd1;
            end
            if (w_good) begin
                r_progValid <= 1'b1;
                r_progLen   <= ADDR_W'(r_count);
            end
            if (w_fail) begin
                r_loadError <= 1'b1;
                r_errCode   <= w_failCode;
            end
        end
    end

    // Program memory write port; contents are masked by prog_valid rather than reset.
    always_ff @(posedge clk) begin
        if (w_wordWrite) begin
            r_mem[r_wordIdx[IDX_W-1:0]] <= w_word;
        end
    end

    // Zero-latency fetch: out-of-range or unverified addresses return a NOP.
    always_comb begin
        fetch_data = 32'h0;
        if (r_progValid && fetch_addr < r_progLen) begin
            fetch_data = r_mem[fetch_addr[IDX_W-1:0]];
        end
    end

    assign load_busy  = (r_state != S_IDLE);
    assign load_done  = r_loadDone;
    assign tpu_start  = r_loadDone;
    assign load_error = r_loadError;
    assign err_code   = r_errCode;
    assign prog_valid = r_progValid;
    assign prog_len   = r_progLen;

endmodule
